regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth is 2^ADDR_W.
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports, range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes are forwarded to reads.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port regno, input, NREAD*ADDR_W, read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rdata, output, NREAD*DATA_W, read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port busy, output, NREAD, per read port; 1 means the addressed register has a pending reservation.
REQ-011 SHALL have port write, input, 1, write enable.
REQ-012 SHALL have port wreg, input, ADDR_W, write index.
REQ-013 SHALL have port wdata, input, DATA_W, write data.
REQ-014 SHALL have port wbe, input, DATA_W/8, byte enables; bit b qualifies wdata[8b+7:8b].
REQ-015 SHALL have port rsv, input, 1, reserve request; marks rsv_reg as pending a write.
REQ-016 SHALL have port rsv_reg, input, ADDR_W, register index to reserve.

Function
REQ-017 Reads SHALL be combinational: rdata[i] = stored word at regno[i], zero added cycles.
REQ-018 On a rising edge with write=1, only bytes with wbe[b]=1 of register wreg SHALL be updated; other bytes are unchanged.
REQ-019 write=1 with wbe all zero SHALL leave data unchanged but still clear the busy bit of wreg.
REQ-020 With BYPASS=1, write=1 and wreg==regno[i], rdata[i] SHALL present enabled wdata bytes merged with the stored bytes in the same cycle.
REQ-021 With BYPASS=0, rdata[i] SHALL show the old value until the edge.
REQ-022 With ZERO_REG=1, a read of index 0 SHALL return 0, writes to 0 SHALL be ignored, and reserving 0 SHALL be ignored; busy for index 0 is always 0.
REQ-023 Scoreboard: one busy bit per register.
  - rsv=1 sets bit rsv_reg at the edge.
  - write=1 clears bit wreg at the edge.
REQ-024 When rsv and write target the same register in the same cycle, the busy bit SHALL end set; data is still written.
REQ-025 busy[i] SHALL equal the stored busy bit of regno[i].
  - With BYPASS=1 it is 0 when write=1 and wreg==regno[i] in that cycle.
  - With BYPASS=0 it is not forced.
REQ-026 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all registers and all busy bits; rdata then reads 0 and busy reads 0 immediately.
REQ-028 Writes and reservations presented while rst_n=0 SHALL be discarded; normal operation resumes at the first rising edge after deassertion.

Structure
REQ-029 Default parameter values and the byte-merge helper function SHALL live in shared package regfile_pkg.
REQ-030 The scoreboard SHALL be a separate sub-module regfile_sb, holding the busy-bit vector and its set/clear logic.
REQ-031 Storage SHALL be flops, not inferred RAM, to allow asynchronous clear and NREAD read ports.

Verification
REQ-032 Reset: drive rst_n=0 mid-run after writing r8=0x0000000F -> rdata for r8 = 0 and all busy = 0 without waiting for a clock edge.
REQ-033 Byte write: r5=0x11223344, then write wbe=0100 wdata=0xAABBCCDD -> r5 reads 0x11BB3344.
REQ-034 Bypass: write r6=0x3 with regno[0]=6 in the same cycle -> rdata[0]=0x3 before the edge when BYPASS=1; shows the old value when BYPASS=0.
REQ-035 Zero register: write r0=0xFFFFFFFF and rsv r0 -> r0 reads 0 and busy stays 0.
REQ-036 Scoreboard:
  - rsv r12 -> busy=1 from the next cycle.
  - write r12=0x555 -> busy=0 after that edge.
  - Simultaneous rsv and write on r12 -> busy=1 and data=0x555.
REQ-037 Multi-port: NREAD=4, all ports read r24 after writing 0x1E0D -> all four rdata equal 0x1E0D.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the byte-lane merge used for writes and write-to-read forwarding.
package regfile_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int NREAD_DEF    = 2;
   localparam int ZERO_REG_DEF = 1;
   localparam int BYPASS_DEF   = 1;

   // Widest word the merge helper handles; callers zero-extend in and truncate out.
   localparam int MERGE_W_MAX  = 256;
   localparam int MERGE_BE_MAX = MERGE_W_MAX / 8;

   function automatic logic [MERGE_W_MAX-1:0] byte_merge(
      input logic [MERGE_W_MAX-1:0]  old_w,
      input logic [MERGE_W_MAX-1:0]  new_w,
      input logic [MERGE_BE_MAX-1:0] be
   );
      logic [MERGE_W_MAX-1:0] res;
      res = old_w;
      for (int b = 0; b < MERGE_BE_MAX; b++) begin
         if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_sb.sv
// Reservation scoreboard: one busy bit per register, set by rsv, cleared by write.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rsv_i,
   input  logic [ADDR_W-1:0]        rsv_reg_i,
   input  logic                     write_i,
   input  logic [ADDR_W-1:0]        wreg_i,
   output logic [(1<<ADDR_W)-1:0]   busy_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Set is applied after clear so a same-cycle reserve of the written register wins.
   always_comb begin
      busy_d = busy_q;
      if (write_i) busy_d[wreg_i] = 1'b0;
      if (rsv_i && !((ZERO_REG != 0) && (rsv_reg_i == '0))) busy_d[rsv_reg_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port flop register file with byte enables, optional r0-is-zero,
// optional write forwarding and a per-register reservation scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NREAD    = NREAD_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int BYPASS   = BYPASS_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREAD*ADDR_W-1:0]  regno,
   output logic [NREAD*DATA_W-1:0]  rdata,
   output logic [NREAD-1:0]         busy,
   input  logic                     write,
   input  logic [ADDR_W-1:0]        wreg,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [DATA_W/8-1:0]      wbe,
   input  logic                     rsv,
   input  logic [ADDR_W-1:0]        rsv_reg
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] wr_word_d;
   logic              wr_en;
   logic [DEPTH-1:0]  sb_busy;

   assign wr_en     = write && !((ZERO_REG != 0) && (wreg == '0));
   assign wr_word_d = DATA_W'(byte_merge(MERGE_W_MAX'(mem_q[wreg]),
                                         MERGE_W_MAX'(wdata),
                                         MERGE_BE_MAX'(wbe)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wreg] <= wr_word_d;
      end
   end

   regfile_sb #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rsv_i     (rsv),
      .rsv_reg_i (rsv_reg),
      .write_i   (write),
      .wreg_i    (wreg),
      .busy_o    (sb_busy)
   );

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] word;
      logic              fwd;

      assign idx = regno[p*ADDR_W +: ADDR_W];
      assign fwd = (BYPASS != 0) && wr_en && (wreg == idx);

      always_comb begin
         word = mem_q[idx];
         if (fwd) word = wr_word_d;
         if ((ZERO_REG != 0) && (idx == '0)) word = '0;
      end

      assign rdata[p*DATA_W +: DATA_W] = word;
      // A write in flight to this register releases its reservation early when forwarding.
      assign busy[p] = sb_busy[idx] & ~((BYPASS != 0) && write && (wreg == idx));
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 4-port forwarding instance and a 2-port non-forwarding one.
module tb_regfile_mp;

   logic        clk;
   logic        rst_n;
   logic [19:0] regno_a;
   logic [9:0]  regno_b;
   logic [127:0] rdata_a;
   logic [63:0] rdata_b;
   logic [3:0]  busy_a;
   logic [1:0]  busy_b;
   logic        write;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic        rsv;
   logic [4:0]  rsv_reg;

   int tests;
   int fails;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .regno(regno_a), .rdata(rdata_a), .busy(busy_a),
      .write(write), .wreg(wreg), .wdata(wdata), .wbe(wbe), .rsv(rsv), .rsv_reg(rsv_reg)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .regno(regno_b), .rdata(rdata_b), .busy(busy_b),
      .write(write), .wreg(wreg), .wdata(wdata), .wbe(wbe), .rsv(rsv), .rsv_reg(rsv_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      write = 1'b1; wreg = r; wdata = d; wbe = be;
      @(posedge clk); #1;
      write = 1'b0; wbe = 4'h0;
   endtask

   task automatic set_ports(input logic [4:0] r);
      for (int i = 0; i < 4; i++) regno_a[i*5 +: 5] = r;
      regno_b = {r, r};
   endtask

   task automatic test_reset;
      set_ports(5'd8);
      #1;
      tests++;
      if (rdata_a[31:0] !== 32'h0 || rdata_b[31:0] !== 32'h0) begin
         fails++; $display("FAIL reset_rdata: a=%h b=%h want 0", rdata_a[31:0], rdata_b[31:0]);
      end
      tests++;
      if (busy_a !== 4'h0 || busy_b !== 2'h0) begin
         fails++; $display("FAIL reset_busy: a=%b b=%b want 0", busy_a, busy_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_byte_write;
      set_ports(5'd5);
      wr(5'd5, 32'h11223344, 4'hF);
      wr(5'd5, 32'hAABBCCDD, 4'b0100);
      #1;
      tests++;
      if (rdata_a[31:0] !== 32'h11BB3344) begin
         fails++; $display("FAIL byte_write_b2: got %h want 11bb3344", rdata_a[31:0]);
      end
      wr(5'd5, 32'hAABBCCDD, 4'b0011);
      #1;
      tests++;
      if (rdata_b[31:0] !== 32'h11BBCCDD) begin
         fails++; $display("FAIL byte_write_b10: got %h want 11bbccdd", rdata_b[31:0]);
      end
   endtask

   task automatic test_bypass;
      set_ports(5'd6);
      wr(5'd6, 32'h0, 4'hF);
      @(negedge clk);
      write = 1'b1; wreg = 5'd6; wdata = 32'h3; wbe = 4'hF;
      #2;
      tests++;
      if (rdata_a[31:0] !== 32'h3) begin
         fails++; $display("FAIL bypass_on: got %h want 3", rdata_a[31:0]);
      end
      tests++;
      if (rdata_b[31:0] !== 32'h0) begin
         fails++; $display("FAIL bypass_off_old: got %h want 0", rdata_b[31:0]);
      end
      @(posedge clk); #1;
      tests++;
      if (rdata_b[31:0] !== 32'h3) begin
         fails++; $display("FAIL bypass_off_after: got %h want 3", rdata_b[31:0]);
      end
      @(negedge clk);
      wdata = 32'hAABBCCDD; wbe = 4'b1000;
      #2;
      tests++;
      if (rdata_a[31:0] !== 32'hAA000003) begin
         fails++; $display("FAIL bypass_partial: got %h want aa000003", rdata_a[31:0]);
      end
      @(posedge clk); #1;
      write = 1'b0; wbe = 4'h0;
   endtask

   task automatic test_zero_reg;
      set_ports(5'd0);
      @(negedge clk);
      write = 1'b1; wreg = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
      rsv = 1'b1; rsv_reg = 5'd0;
      #2;
      tests++;
      if (rdata_a[31:0] !== 32'h0) begin
         fails++; $display("FAIL zero_fwd: got %h want 0", rdata_a[31:0]);
      end
      @(posedge clk); #1;
      write = 1'b0; rsv = 1'b0; wbe = 4'h0;
      #1;
      tests++;
      if (rdata_a[31:0] !== 32'h0 || rdata_b[31:0] !== 32'h0) begin
         fails++; $display("FAIL zero_read: a=%h b=%h want 0", rdata_a[31:0], rdata_b[31:0]);
      end
      tests++;
      if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
         fails++; $display("FAIL zero_busy: a=%b b=%b want 0", busy_a[0], busy_b[0]);
      end
   endtask

   task automatic test_scoreboard;
      set_ports(5'd12);
      @(negedge clk);
      rsv = 1'b1; rsv_reg = 5'd12;
      #2;
      tests++;
      if (busy_a[0] !== 1'b0) begin
         fails++; $display("FAIL sb_before_edge: got %b want 0", busy_a[0]);
      end
      @(posedge clk); #1;
      rsv = 1'b0;
      #1;
      tests++;
      if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
         fails++; $display("FAIL sb_set: a=%b b=%b want 1", busy_a[0], busy_b[0]);
      end
      @(negedge clk);
      write = 1'b1; wreg = 5'd12; wdata = 32'h555; wbe = 4'hF;
      #2;
      tests++;
      if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
         fails++; $display("FAIL sb_busy_fwd: a=%b b=%b want a=0 b=1", busy_a[0], busy_b[0]);
      end
      @(posedge clk); #1;
      write = 1'b0; wbe = 4'h0;
      #1;
      tests++;
      if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
         fails++; $display("FAIL sb_clear: a=%b b=%b want 0", busy_a[0], busy_b[0]);
      end
      @(negedge clk);
      write = 1'b1; wreg = 5'd12; wdata = 32'h555; wbe = 4'hF;
      rsv = 1'b1; rsv_reg = 5'd12;
      @(posedge clk); #1;
      write = 1'b0; rsv = 1'b0; wbe = 4'h0;
      #1;
      tests++;
      if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
         fails++; $display("FAIL sb_simul_busy: a=%b b=%b want 1", busy_a[0], busy_b[0]);
      end
      tests++;
      if (rdata_a[31:0] !== 32'h555) begin
         fails++; $display("FAIL sb_simul_data: got %h want 555", rdata_a[31:0]);
      end
      wr(5'd12, 32'hFFFF, 4'h0);
      #1;
      tests++;
      if (busy_b[1] !== 1'b0 || rdata_b[63:32] !== 32'h555) begin
         fails++; $display("FAIL sb_wbe_zero: busy=%b data=%h want 0/555", busy_b[1], rdata_b[63:32]);
      end
   endtask

   task automatic test_multiport;
      wr(5'd24, 32'h1E0D, 4'hF);
      set_ports(5'd24);
      #1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (rdata_a[i*32 +: 32] !== 32'h1E0D || busy_a[i] !== 1'b0) begin
            fails++; $display("FAIL mp_same_port%0d: data=%h busy=%b want 1e0d/0", i, rdata_a[i*32 +: 32], busy_a[i]);
         end
      end
      regno_a = {5'd24, 5'd12, 5'd6, 5'd5};
      #1;
      tests++;
      if (rdata_a !== {32'h1E0D, 32'h555, 32'hAA000003, 32'h11BBCCDD}) begin
         fails++; $display("FAIL mp_distinct: got %h", rdata_a);
      end
   endtask

   task automatic test_async_reset;
      wr(5'd8, 32'h0000000F, 4'hF);
      @(negedge clk);
      rsv = 1'b1; rsv_reg = 5'd9;
      @(posedge clk); #1;
      rsv = 1'b0;
      regno_a = {5'd9, 5'd9, 5'd9, 5'd8};
      #1;
      tests++;
      if (rdata_a[31:0] !== 32'hF || busy_a[1] !== 1'b1) begin
         fails++; $display("FAIL pre_reset: data=%h busy=%b want f/1", rdata_a[31:0], busy_a[1]);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (rdata_a[31:0] !== 32'h0) begin
         fails++; $display("FAIL async_reset_data: got %h want 0", rdata_a[31:0]);
      end
      tests++;
      if (busy_a !== 4'h0) begin
         fails++; $display("FAIL async_reset_busy: got %b want 0", busy_a);
      end
      write = 1'b1; wreg = 5'd8; wdata = 32'h77; wbe = 4'hF;
      rsv = 1'b1; rsv_reg = 5'd8;
      @(posedge clk);
      @(negedge clk);
      write = 1'b0; rsv = 1'b0; wbe = 4'h0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (rdata_a[31:0] !== 32'h0 || busy_a[0] !== 1'b0) begin
         fails++; $display("FAIL reset_discard: data=%h busy=%b want 0/0", rdata_a[31:0], busy_a[0]);
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0;
      regno_a = '0; regno_b = '0;
      write = 1'b0; wreg = '0; wdata = '0; wbe = '0;
      rsv = 1'b0; rsv_reg = '0;
      test_reset();
      test_byte_write();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_multiport();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
